// File: rtl/vga_mem_arbiter_pkg.sv
// Shared definitions for the VGA memory arbiter: target select codes,
// FSM state encoding, master indices and the latched access record.
package vga_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SEL_GRAPH  = 2'b00,
    SEL_TEXT   = 2'b01,
    SEL_CURSOR = 2'b10,
    SEL_REG    = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    RDWAIT = 2'b10,
    ACK    = 2'b11
  } state_e;

  localparam logic M0 = 1'b0;  // CPU
  localparam logic M1 = 1'b1;  // fill/scroll engine

  // Access captured from the winning master at grant time
  typedef struct packed {
    sel_e        sel;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// One master's request/response port into the arbiter.
interface vga_mem_arbiter_if;
  logic        req;
  logic [1:0]  sel;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, sel, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, sel, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vga_mem_arbiter_pick.sv
// Winner selection for the two-master arbiter plus the anti-starvation
// burst counter. Tie policy: fixed (master 0 wins) by default, alternating
// when VGA_ARB_ROUND_ROBIN_EN is defined. In both modes a master that has
// taken MAX_BURST consecutive contested grants yields the next one.
module vga_arb_pick
  import vga_mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       grant_i,  // a grant is taken this cycle
  output logic       win_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic          last_q;
  logic [CW-1:0] burst_q;
  logic          limit;
  logic          tie_win;
  logic          other_req;

`ifdef VGA_ARB_ROUND_ROBIN_EN
  logic prio_q;  // master favoured on the next tie
`endif

  // Pick the winner from current requests and grant history
  always_comb begin
    limit = (burst_q >= CW'(MAX_BURST));
`ifdef VGA_ARB_ROUND_ROBIN_EN
    tie_win = prio_q;
`else
    tie_win = M0;
`endif
    if (&req_i) win_o = limit ? ~last_q : tie_win;
    else        win_o = req_i[1] ? M1 : M0;
    other_req = win_o ? req_i[0] : req_i[1];
  end

  // Track consecutive grants to the same master while the other waits
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= M0;
      burst_q <= '0;
`ifdef VGA_ARB_ROUND_ROBIN_EN
      prio_q  <= M0;
`endif
    end else if (grant_i) begin
      last_q <= win_o;
`ifdef VGA_ARB_ROUND_ROBIN_EN
      prio_q <= ~win_o;
`endif
      if (!other_req)
        burst_q <= '0;
      else if (win_o != last_q)
        burst_q <= CW'(1);
      else if (!limit)
        burst_q <= burst_q + CW'(1);
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Two-master arbiter in front of the VGA graph/text/cursor/register targets.
// Latches the winner's access, issues one strobe (stalling on busy when
// STALL_BUSY=1), captures read data and returns a one-cycle ack.
// Tie policy macro: VGA_ARB_ROUND_ROBIN_EN (see vga_arb_pick).
module vga_mem_arbiter
  import vga_mem_arbiter_pkg::*;
#(
  parameter bit STALL_BUSY = 1'b1,
  parameter int MAX_BURST  = 4
) (
  input  logic        clk,
  input  logic        rst,
  vga_mem_arbiter_if.slave m0,
  vga_mem_arbiter_if.slave m1,
  output logic [3:0]  we_text,
  output logic [3:0]  we_graph,
  output logic [3:0]  we_cursor,
  output logic [3:0]  we_reg,
  output logic        rd_text,
  output logic        rd_graph,
  output logic        rd_cursor,
  output logic        rd_reg,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] text_rdata,
  input  logic [31:0] graph_rdata,
  input  logic [31:0] cursor_rdata,
  input  logic [31:0] reg_rdata,
  input  logic        busy
);

  state_e           state_q;
  logic             win_q;
  acc_t             acc_q;
  logic [3:0][3:0]  we_q;     // indexed by sel_e
  logic [3:0]       rd_q;     // indexed by sel_e
  logic [1:0]       ack_q;
  logic [1:0][31:0] rdata_q;

  logic [1:0]  req;
  logic        win;
  logic        grant;
  acc_t        pay;
  logic [31:0] tgt_rdata;

  assign req   = {m1.req, m0.req};
  assign grant = (state_q == IDLE) && (|req);

  vga_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .grant_i (grant),
    .win_o   (win)
  );

  // Payload of whichever master is winning this cycle
  always_comb begin
    pay = '{sel: sel_e'(m0.sel), we: m0.we, addr: m0.addr, wdata: m0.wdata};
    if (win == M1)
      pay = '{sel: sel_e'(m1.sel), we: m1.we, addr: m1.addr, wdata: m1.wdata};
  end

  // Read data of the latched target
  always_comb begin
    tgt_rdata = graph_rdata;
    case (acc_q.sel)
      SEL_TEXT:   tgt_rdata = text_rdata;
      SEL_CURSOR: tgt_rdata = cursor_rdata;
      SEL_REG:    tgt_rdata = reg_rdata;
      default:    tgt_rdata = graph_rdata;
    endcase
  end

  // Access FSM; strobes and acks are single-cycle registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= M0;
      acc_q   <= '0;
      we_q    <= '0;
      rd_q    <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      we_q  <= '0;
      rd_q  <= '0;
      ack_q <= '0;
      case (state_q)
        IDLE: if (grant) begin
          win_q   <= win;
          acc_q   <= pay;
          state_q <= ISSUE;
        end
        ISSUE: if (!(STALL_BUSY && busy)) begin
          if (|acc_q.we) begin
            we_q[acc_q.sel] <= acc_q.we;
            state_q         <= ACK;
          end else begin
            rd_q[acc_q.sel] <= 1'b1;
            state_q         <= RDWAIT;
          end
        end
        RDWAIT: begin
          rdata_q[win_q] <= tgt_rdata;
          state_q        <= ACK;
        end
        ACK: begin
          ack_q[win_q] <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign we_graph  = we_q[SEL_GRAPH];
  assign we_text   = we_q[SEL_TEXT];
  assign we_cursor = we_q[SEL_CURSOR];
  assign we_reg    = we_q[SEL_REG];
  assign rd_graph  = rd_q[SEL_GRAPH];
  assign rd_text   = rd_q[SEL_TEXT];
  assign rd_cursor = rd_q[SEL_CURSOR];
  assign rd_reg    = rd_q[SEL_REG];
  assign addr      = acc_q.addr;
  assign wdata     = acc_q.wdata;
  assign m0.ack    = ack_q[M0];
  assign m1.ack    = ack_q[M1];
  assign m0.rdata  = rdata_q[M0];
  assign m1.rdata  = rdata_q[M1];

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed + randomized bench for vga_mem_arbiter against a transaction-level
// model: expected strobe, latency, read data and grant order per access.
module tb_vga_mem_arbiter;

  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_mem_arbiter_if m0_if ();
  vga_mem_arbiter_if m1_if ();

  logic [3:0]  we_text, we_graph, we_cursor, we_reg;
  logic        rd_text, rd_graph, rd_cursor, rd_reg;
  logic [31:0] addr, wdata;
  logic [31:0] text_rdata, graph_rdata, cursor_rdata, reg_rdata;
  logic        busy;

  vga_mem_arbiter #(.STALL_BUSY(1'b1), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .we_text(we_text), .we_graph(we_graph), .we_cursor(we_cursor), .we_reg(we_reg),
    .rd_text(rd_text), .rd_graph(rd_graph), .rd_cursor(rd_cursor), .rd_reg(rd_reg),
    .addr(addr), .wdata(wdata),
    .text_rdata(text_rdata), .graph_rdata(graph_rdata),
    .cursor_rdata(cursor_rdata), .reg_rdata(reg_rdata),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic r, input logic [1:0] s,
                       input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_if.req = r; m0_if.sel = s; m0_if.we = w; m0_if.addr = a; m0_if.wdata = d;
    end else begin
      m1_if.req = r; m1_if.sel = s; m1_if.we = w; m1_if.addr = a; m1_if.wdata = d;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  function automatic logic [15:0] wvec();
    return {we_reg, we_cursor, we_text, we_graph};
  endfunction

  function automatic logic [3:0] rvec();
    return {rd_reg, rd_cursor, rd_text, rd_graph};
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},    32'(wvec()), 32'h0);
    chk({tag, "_rd"},    32'(rvec()), 32'h0);
    chk({tag, "_ack"},   32'({m1_if.ack, m0_if.ack}), 32'h0);
    chk({tag, "_addr"},  addr, 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
    chk({tag, "_rd0"},   m0_if.rdata, 32'h0);
    chk({tag, "_rd1"},   m1_if.rdata, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One access from master m. The target's read value is tval; the payload
  // is scrambled right after the grant edge, and req is optionally dropped
  // there too. busy stays high for the first busy_len sample points.
  task automatic txn(input string tag, input int m, input logic [1:0] sel,
                     input logic [3:0] we, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] tval, input int busy_len, input bit drop);
    logic [31:0] tv [4];
    logic [31:0] rnd;
    logic [15:0] s_wv, e_wv;
    logic [3:0]  s_rv, e_rv;
    logic [31:0] s_addr, s_wdata, ack_rd;
    int strobe_cyc, nstrobe, ack_cyc, other_ack, e_strobe, e_ack;
    strobe_cyc = -1; nstrobe = 0; ack_cyc = -1; other_ack = 0;
    s_wv = '0; s_rv = '0; s_addr = '0; s_wdata = '0; ack_rd = '0;
    for (int i = 0; i < 4; i++) tv[i] = $urandom;
    tv[sel] = tval;
    graph_rdata = tv[0]; text_rdata = tv[1]; cursor_rdata = tv[2]; reg_rdata = tv[3];
    busy = (busy_len > 0);
    drive(m, 1'b1, sel, we, a, d);
    for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rnd = $urandom;
        drive(m, !drop, rnd[1:0], rnd[7:4], $urandom, $urandom);
      end
      if ((|wvec()) || (|rvec())) begin
        nstrobe++;
        strobe_cyc = c;
        s_wv = wvec(); s_rv = rvec(); s_addr = addr; s_wdata = wdata;
      end
      if (ack_of(1 - m)) other_ack++;
      if (ack_of(m)) begin
        ack_cyc = c;
        ack_rd  = rdata_of(m);
        drive(m, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0);
      end
      if (c == busy_len) busy = 1'b0;
    end
    busy = 1'b0;
    e_strobe = (busy_len + 1 > 2) ? busy_len + 1 : 2;
    e_ack    = e_strobe + ((we != 4'h0) ? 1 : 2);
    e_wv = '0; e_rv = '0;
    if (we != 4'h0) e_wv[sel*4 +: 4] = we;
    else begin
      e_rv[sel]  = 1'b1;
      exp_rd[m]  = tval;
    end
    chk({tag, "_nstrobe"},   32'(nstrobe), 32'd1);
    chk({tag, "_strobecyc"}, 32'(strobe_cyc), 32'(e_strobe));
    chk({tag, "_we"},        32'(s_wv), 32'(e_wv));
    chk({tag, "_rd"},        32'(s_rv), 32'(e_rv));
    chk({tag, "_addr"},      s_addr, a);
    chk({tag, "_wdata"},     s_wdata, d);
    chk({tag, "_ackcyc"},    32'(ack_cyc), 32'(e_ack));
    chk({tag, "_otherack"},  32'(other_ack), 32'd0);
    chk({tag, "_ackrdata"},  ack_rd, exp_rd[m]);
    @(negedge clk);
    chk({tag, "_ackpulse"},  32'(ack_of(m)), 32'd0);
    chk({tag, "_rdhold"},    rdata_of(m), exp_rd[m]);
    chk({tag, "_rdother"},   rdata_of(1 - m), exp_rd[1 - m]);
  endtask

  initial begin
    int grants[$];
    logic [31:0] r, tv;
    logic [3:0]  w;
    int ge;

    drive(0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0);
    busy = 1'b0;
    text_rdata = '0; graph_rdata = '0; cursor_rdata = '0; reg_rdata = '0;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Directed accesses
    txn("m0_wr_text", 0, 2'b01, 4'hF, 32'h10, 32'hA5, $urandom, 0, 1'b0);
    txn("m1_rd_reg",  1, 2'b11, 4'h0, 32'h20, 32'h0, 32'h12340003, 0, 1'b0);
    txn("m0_wr_busy", 0, 2'b00, 4'hF, 32'h44, 32'h5A5A, $urandom, 10, 1'b0);
    txn("m1_rd_busy", 1, 2'b10, 4'h0, 32'h48, 32'h0, 32'hCAFE0001, 4, 1'b0);
    txn("m0_rd_drop", 0, 2'b01, 4'h0, 32'h50, 32'h0, 32'hBEEF0002, 2, 1'b1);
    txn("m1_wr_drop", 1, 2'b11, 4'h3, 32'h54, 32'h77, $urandom, 0, 1'b1);

    // Random single-master accesses
    for (int k = 0; k < 24; k++) begin
      r  = $urandom;
      tv = $urandom;
      w  = r[8] ? 4'h0 : ((r[3:0] == 4'h0) ? 4'h1 : r[3:0]);
      txn("rand", int'(r[9]), r[5:4], w, $urandom, $urandom, tv,
          int'(r[11:10]), (r[13:12] == 2'b00));
    end

    // Contention from reset: both masters request continuously
    do_reset();
    drive(0, 1'b1, 2'b01, 4'hF, 32'h100, 32'h1);
    drive(1, 1'b1, 2'b01, 4'hF, 32'h200, 32'h2);
    for (int c = 0; c < 400 && grants.size() < 10; c++) begin
      @(negedge clk);
      if (m0_if.ack) grants.push_back(0);
      if (m1_if.ack) grants.push_back(1);
    end
    drive(0, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0);
    chk("contend_count", 32'(grants.size()), 32'd10);
    for (int k = 0; k < grants.size(); k++) begin
`ifdef VGA_ARB_ROUND_ROBIN_EN
      ge = k % 2;
`else
      ge = ((k % (MB + 1)) == MB) ? 1 : 0;
`endif
      chk($sformatf("contend_grant%0d", k), 32'(grants[k]), 32'(ge));
    end
    repeat (2) @(negedge clk);

    // Reset while the read sits in RDWAIT
    reg_rdata = 32'h0BAD0BAD;
    drive(1, 1'b1, 2'b11, 4'h0, 32'h300, 32'h0);
    repeat (2) @(negedge clk);
    chk("rstmid_strobe", 32'(rd_reg), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1'b0, 2'b00, 4'h0, 32'h0, 32'h0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    check_all_zero("rstmid");
    @(negedge clk);
    chk("rstmid_noack", 32'({m1_if.ack, m0_if.ack}), 32'h0);
    chk("rstmid_nostrobe", 32'({wvec(), rvec()}), 32'h0);
    txn("post_rst_rd", 1, 2'b11, 4'h0, 32'h304, 32'h0, 32'h12340003, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter STALL_BUSY, default 1, meaning 1 = no access issued while busy is high.
REQ-002 SHALL have parameter MAX_BURST, default 4, meaning consecutive grants one master may hold while the other waits.
REQ-003 SHALL have port clk, input, 1, system clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports mN_req, input, 1, access request; N = 0 (CPU), 1 (fill/scroll engine).
REQ-006 SHALL have ports mN_sel, input, 2, target: 00 graph, 01 text, 10 cursor, 11 reg.
REQ-007 SHALL have ports mN_we, input, 4, byte write enables; 0 means read.
REQ-008 SHALL have ports mN_addr, input, 32, address; mN_wdata, input, 32, write data.
REQ-009 SHALL have ports mN_ack, output, 1, one-cycle completion pulse; mN_rdata, output, 32, read data valid with ack.
REQ-010 SHALL have ports we_text/we_graph/we_cursor/we_reg, output, 4 each, target write strobes.
REQ-011 SHALL have ports rd_text/rd_graph/rd_cursor/rd_reg, output, 1 each, target read strobes.
REQ-012 SHALL have ports addr, output, 32, and wdata, output, 32, shared target address/data.
REQ-013 SHALL have ports text_rdata/graph_rdata/cursor_rdata/reg_rdata, input, 32 each.
REQ-014 SHALL have port busy, input, 1, display-side read in progress.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RDWAIT, ACK.
REQ-016 IDLE: any mN_req high SHALL latch winner's sel/we/addr/wdata and move to ISSUE next cycle.
REQ-017 ISSUE: if STALL_BUSY=1 and busy high, SHALL hold in ISSUE with all strobes low; otherwise SHALL assert exactly one strobe for one cycle.
REQ-018 ISSUE with write SHALL go to ACK; with read SHALL go to RDWAIT.
REQ-019 RDWAIT SHALL capture the rdata of the latched target into mN_rdata and go to ACK.
REQ-020 ACK SHALL pulse winner's mN_ack for one cycle and return to IDLE; write latency 3 cycles from req with busy low; read latency 4.
REQ-021 Masters SHALL hold req and payload until ack; the arbiter SHALL ignore payload changes after latch.
REQ-022 Simultaneous requests SHALL be resolved per the Configuration section policy.
REQ-023 After MAX_BURST consecutive grants to one master with the other requesting, the next grant SHALL go to the other master.
REQ-024 mN_rdata SHALL hold its last value until the next read ack to that master.
REQ-025 A master dropping req in ISSUE SHALL NOT cancel the access.

Reset
REQ-026 rst SHALL force IDLE, all strobes 0, acks 0, addr/wdata/mN_rdata 0, burst counter 0, priority pointer to master 0.
REQ-027 rst mid-transaction SHALL abort it with no ack and no strobe in the following cycle.

Configuration
REQ-028 Macro VGA_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant SHALL alternate, with last-granted master losing.
REQ-029 Macro VGA_ARB_ROUND_ROBIN_EN undefined: master 0 SHALL win ties, with REQ-023 still limiting starvation.

Structure
REQ-030 A shared package SHALL hold the sel encodings, FSM state encoding, and the master index constants.
REQ-031 One sub-module, vga_arb_pick (winner selection plus burst counter), SHALL be used; the FSM and muxing SHALL stay in the top module.

Verification
REQ-032 m0 write sel=01 addr=0x10 we=F wdata=0xA5, busy=0 -> we_text=F for exactly one cycle, m0_ack 3 cycles after req.
REQ-033 m1 read sel=11, reg_rdata=0x12340003 -> rd_reg one cycle, m1_rdata=0x12340003 with m1_ack at cycle 4.
REQ-034 m0 write with busy high for 10 cycles -> no strobe while busy is high; strobe on the first busy-low cycle.
REQ-035 Both masters continuously requesting, round-robin enabled -> grants 0,1,0,1; with the macro disabled -> grants 0,0,0,0,1 (MAX_BURST=4).
REQ-036 rst asserted in RDWAIT -> no ack, all outputs 0 next cycle; a new request afterwards completes normally.
